// File: rtl/ex_issue.sv
// ex_issue -- execute-stage issue/output register pair with operand forwarding.
//
// Two pipeline registers sit around an external combinational ALU:
//   ISSUE holds a decoded instruction with its operands already resolved and
//         drives the ALU directly (alu_src_a/alu_src_b/alu_control).
//   OUT   captures the ALU result and destination register for the MEM stage.
// Operands are resolved once, at transfer time, using the youngest producer
// first: the result being captured into OUT at the same edge, then the OUT
// register, then the MEM and WB writeback candidates, then the register file.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   in_valid/in_ready                decoded-instruction handshake from ID
//   in_op, in_rs_a, in_rs_b, in_rd   opcode and register indices
//   in_val_a, in_val_b, in_imm       register-file operands and immediate
//   in_use_imm                       operand B comes from in_imm, never forwarded
//   fwd_mem_*, fwd_wb_*              writeback candidates from MEM and WB
//   alu_src_a, alu_src_b, alu_control, alu_result   external ALU interface
//   out_valid/out_ready, out_result, out_rd         result handshake toward MEM
//   flush                            synchronous kill of ISSUE and OUT
//   bad_op                           sticky illegal-opcode flag, cleared by reset
//
// Parameter FWD_EN: 1 enables forwarding, 0 always uses in_val_a/in_val_b.

module ex_issue #(
  parameter int unsigned FWD_EN = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rs_a,
  input  logic [4:0]  in_rs_b,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_val_a,
  input  logic [31:0] in_val_b,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,

  input  logic        fwd_mem_valid,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [31:0] fwd_mem_data,
  input  logic        fwd_wb_valid,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_wb_data,

  output logic [31:0] alu_src_a,
  output logic [31:0] alu_src_b,
  output logic [4:0]  alu_control,
  input  logic [31:0] alu_result,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,

  input  logic        flush,
  output logic        bad_op
);

  // ALU operation codes shared with the decoder.
  localparam logic [4:0] ALU_AND = 5'h00;
  localparam logic [4:0] ALU_OR  = 5'h01;
  localparam logic [4:0] ALU_add = 5'h02;
  localparam logic [4:0] ALU_sub = 5'h06;

  // ISSUE register
  logic        issue_full_q, issue_full_d;
  logic [4:0]  issue_op_q,   issue_op_d;
  logic [31:0] issue_a_q,    issue_a_d;
  logic [31:0] issue_b_q,    issue_b_d;
  logic [4:0]  issue_rd_q,   issue_rd_d;

  // OUT register
  logic        out_full_q,   out_full_d;
  logic [31:0] out_result_q, out_result_d;
  logic [4:0]  out_rd_q,     out_rd_d;

  logic        bad_op_q,     bad_op_d;

  logic        capture;
  logic        transfer;
  logic        op_legal;
  logic [31:0] cap_result;
  logic [31:0] res_a;
  logic [31:0] res_b;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign capture  = issue_full_q && (!out_full_q || out_ready);
  // reset gates in_ready so nothing is offered as accepted while held in reset
  assign in_ready = !reset && !flush && (!issue_full_q || capture);
  assign transfer = in_valid && in_ready;

  always_comb begin
    unique case (issue_op_q)
      ALU_AND, ALU_OR, ALU_add, ALU_sub: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
  end

  assign cap_result = op_legal ? alu_result : 32'h0;

  // ---------------------------------------------------------------------------
  // Operand resolution
  // ---------------------------------------------------------------------------
  // A transfer can only coincide with a capture (or an empty ISSUE), so the
  // value landing in OUT this edge is the youngest producer and wins first.
  function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] rf_val);
    logic [31:0] val;
    val = rf_val;
    if (FWD_EN != 0 && rs != 5'd0) begin
      if (capture && issue_rd_q == rs) begin
        val = cap_result;
      end else if (out_full_q && out_rd_q == rs) begin
        val = out_result_q;
      end else if (fwd_mem_valid && fwd_mem_rd == rs) begin
        val = fwd_mem_data;
      end else if (fwd_wb_valid && fwd_wb_rd == rs) begin
        val = fwd_wb_data;
      end
    end
    return val;
  endfunction

  always_comb begin
    res_a = resolve(in_rs_a, in_val_a);
    res_b = in_use_imm ? in_imm : resolve(in_rs_b, in_val_b);
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    issue_full_d = issue_full_q;
    issue_op_d   = issue_op_q;
    issue_a_d    = issue_a_q;
    issue_b_d    = issue_b_q;
    issue_rd_d   = issue_rd_q;
    out_full_d   = out_full_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    bad_op_d     = bad_op_q;

    if (flush) begin
      // flush beats capture; in_ready is already 0 so no transfer can occur
      issue_full_d = 1'b0;
      out_full_d   = 1'b0;
    end else begin
      if (transfer) begin
        issue_full_d = 1'b1;
        issue_op_d   = in_op;
        issue_a_d    = res_a;
        issue_b_d    = res_b;
        issue_rd_d   = in_rd;
      end else if (capture) begin
        issue_full_d = 1'b0;
      end

      if (capture) begin
        out_full_d   = 1'b1;
        out_result_d = cap_result;
        out_rd_d     = issue_rd_q;
        if (!op_legal) begin
          bad_op_d = 1'b1;
        end
      end else if (out_ready) begin
        out_full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_full_q <= 1'b0;
      issue_op_q   <= 5'h0;
      issue_a_q    <= 32'h0;
      issue_b_q    <= 32'h0;
      issue_rd_q   <= 5'h0;
      out_full_q   <= 1'b0;
      out_result_q <= 32'h0;
      out_rd_q     <= 5'h0;
      bad_op_q     <= 1'b0;
    end else begin
      issue_full_q <= issue_full_d;
      issue_op_q   <= issue_op_d;
      issue_a_q    <= issue_a_d;
      issue_b_q    <= issue_b_d;
      issue_rd_q   <= issue_rd_d;
      out_full_q   <= out_full_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      bad_op_q     <= bad_op_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alu_src_a   = issue_a_q;
  assign alu_src_b   = issue_b_q;
  assign alu_control = issue_op_q;
  assign out_valid   = out_full_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign bad_op      = bad_op_q;

endmodule
